// File: rtl/sd_spi_master.sv
// SPI master for the Mini8086 I/O space: byte TX/RX FIFOs, programmable divider,
// SPI modes 0-3, up to two chip selects, overrun flag and maskable interrupts.
module sd_spi_master #(
   parameter int DIV_W      = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int NUM_CS     = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs_drive,
   input  logic              RD,
   input  logic              WR,
   input  logic [1:0]        ADDR,
   inout  wire  [7:0]        DATA,
   input  logic              CARD_DET,
   input  logic              MISO,
   output logic              SCLK,
   output logic              MOSI,
   output logic [NUM_CS-1:0] SD_CS,
   output logic              LD_GN,
   output logic              LD_RD,
   output logic              SD_IRQ,
   output logic [1:0]        dbg_state
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic [7:0]    CTRL_MASK = (NUM_CS > 1) ? 8'hFF : 8'h7F;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   state_t state_q, state_d;
   logic [7:0] ctrl_q, rdata, wdata;
   logic [DIV_W-1:0] div_r, div_l, div_cnt;
   logic wr_q, rd_q, wr_stb, rd_pop, flush;
   logic wr_ctrl, wr_stat, wr_data, wr_div;
   logic [7:0] tx_mem [FIFO_DEPTH];
   logic [7:0] rx_mem [FIFO_DEPTH];
   logic [AW-1:0] tx_rp, tx_wp, rx_rp, rx_wp;
   logic [CW-1:0] tx_cnt, rx_cnt;
   logic tx_empty, tx_full, rx_empty, rx_full;
   logic tx_push, tx_pop, rx_push, rx_pop;
   logic st_done, done_set, ovr_set, card_set;
   logic card_s1, card_s, ovr_f, done_f, chg_f, busy;
   logic cpol_l, cpha_l, sclk_r, mosi_r, irq_r;
   logic [3:0] hcnt;
   logic [7:0] tx_sh, rx_sh;
   logic tick, sample_edge, shift_edge;

   // Bus strobes: write commits once per WR low pulse, read pop on RD rising edge.
   assign wdata   = DATA;
   assign wr_stb  = cs_drive & ~WR & wr_q;
   assign rd_pop  = cs_drive & RD & ~rd_q & (ADDR == 2'd2);
   assign wr_ctrl = wr_stb & (ADDR == 2'd0);
   assign wr_stat = wr_stb & (ADDR == 2'd1);
   assign wr_data = wr_stb & (ADDR == 2'd2);
   assign wr_div  = wr_stb & (ADDR == 2'd3);
   assign flush   = wr_stat & wdata[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q   <= 1'b1;
         rd_q   <= 1'b1;
         ctrl_q <= '0;
         div_r  <= '1;
      end else begin
         wr_q <= WR;
         rd_q <= RD;
         if (wr_ctrl) ctrl_q <= wdata & CTRL_MASK;
         if (wr_div)  div_r  <= wdata[DIV_W-1:0];
      end
   end

   assign tx_empty = (tx_cnt == '0);
   assign tx_full  = (tx_cnt == FULL_CNT);
   assign rx_empty = (rx_cnt == '0);
   assign rx_full  = (rx_cnt == FULL_CNT);
   assign tx_push  = wr_data & (~tx_full | tx_pop);
   assign rx_pop   = rd_pop & ~rx_empty;
   assign rx_push  = st_done & (~rx_full | flush);
   assign ovr_set  = st_done & rx_full & ~flush;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         tx_rp  <= '0;
         tx_wp  <= '0;
         tx_cnt <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + AW'(1);
         if (tx_pop)  tx_rp <= tx_rp + AW'(1);
         tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      end
   end

   // A flush coinciding with the engine's push keeps the new byte in slot 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_rp  <= '0;
         rx_wp  <= '0;
         rx_cnt <= '0;
      end else if (flush) begin
         rx_rp  <= '0;
         rx_wp  <= AW'(rx_push);
         rx_cnt <= CW'(rx_push);
      end else begin
         if (rx_push) rx_wp <= rx_wp + AW'(1);
         if (rx_pop)  rx_rp <= rx_rp + AW'(1);
         rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp] <= wdata;
      if (rx_push) rx_mem[flush ? '0 : rx_wp] <= rx_sh;
   end

   // Sticky flags: a hardware set in the same cycle as a write-1-to-clear wins.
   assign card_set = card_s1 ^ card_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         card_s1 <= 1'b0;
         card_s  <= 1'b0;
         ovr_f   <= 1'b0;
         done_f  <= 1'b0;
         chg_f   <= 1'b0;
         irq_r   <= 1'b0;
      end else begin
         card_s1 <= CARD_DET;
         card_s  <= card_s1;
         ovr_f   <= ovr_set  | (ovr_f  & ~(wr_stat & wdata[5]));
         done_f  <= done_set | (done_f & ~(wr_stat & wdata[6]));
         chg_f   <= card_set | (chg_f  & ~(wr_stat & wdata[7]));
         irq_r   <= (ctrl_q[5] & done_f) | (ctrl_q[6] & chg_f);
      end
   end

   assign busy = (state_q != S_IDLE) | ~tx_empty;

   always_comb begin
      rdata = 8'h00;
      case (ADDR)
         2'd0: rdata = ctrl_q;
         2'd1: rdata = {chg_f, done_f, ovr_f, rx_empty, tx_empty, tx_full, card_s, busy};
         2'd2: rdata = rx_empty ? 8'hFF : rx_mem[rx_rp];
         default: rdata = 8'(div_r);
      endcase
   end

   assign DATA = (cs_drive && !RD) ? rdata : 8'bz;

   // Engine. hcnt counts SCLK half periods; even values are leading edges.
   assign tick        = (state_q == S_SHIFT) && (div_cnt == div_l);
   assign sample_edge = tick && (hcnt[0] == cpha_l);
   assign shift_edge  = tick && (hcnt[0] != cpha_l);

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      tx_pop   = 1'b0;
      st_done  = 1'b0;
      done_set = 1'b0;
      case (state_q)
         S_IDLE:  if (!tx_empty) state_d = S_LOAD;
         S_LOAD: begin
            tx_pop  = ~tx_empty;
            state_d = tx_empty ? S_IDLE : S_SHIFT;
         end
         S_SHIFT: if (tick && hcnt == 4'd15) state_d = S_DONE;
         S_DONE: begin
            st_done = 1'b1;
            if (tx_empty) begin
               done_set = 1'b1;
               state_d  = S_IDLE;
            end else begin
               state_d  = S_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cpol_l  <= 1'b0;
         cpha_l  <= 1'b0;
         div_l   <= '1;
         div_cnt <= '0;
         hcnt    <= '0;
         tx_sh   <= '1;
         rx_sh   <= '0;
         sclk_r  <= 1'b0;
         mosi_r  <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               sclk_r <= ctrl_q[0];
               mosi_r <= 1'b1;
            end
            S_LOAD: if (tx_pop) begin
               cpol_l  <= ctrl_q[0];
               cpha_l  <= ctrl_q[1];
               div_l   <= div_r;
               div_cnt <= '0;
               hcnt    <= '0;
               sclk_r  <= ctrl_q[0];
               rx_sh   <= '0;
               // CPHA=0 presents the MSB before the first edge; CPHA=1 on it.
               if (!ctrl_q[1]) begin
                  mosi_r <= tx_mem[tx_rp][7];
                  tx_sh  <= {tx_mem[tx_rp][6:0], 1'b1};
               end else begin
                  mosi_r <= 1'b1;
                  tx_sh  <= tx_mem[tx_rp];
               end
            end
            S_SHIFT: begin
               if (tick) begin
                  div_cnt <= '0;
                  hcnt    <= hcnt + 4'd1;
                  sclk_r  <= ~sclk_r;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
               if (sample_edge) rx_sh <= {rx_sh[6:0], MISO};
               if (shift_edge) begin
                  mosi_r <= tx_sh[7];
                  tx_sh  <= {tx_sh[6:0], 1'b1};
               end
            end
            default: begin
               sclk_r <= cpol_l;
               mosi_r <= 1'b1;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_CS; i++) begin : g_cs
      assign SD_CS[i] = ~(ctrl_q[2] & (ctrl_q[7] == 1'(i)));
   end

   assign SCLK      = sclk_r;
   assign MOSI      = mosi_r;
   assign LD_GN     = ctrl_q[3];
   assign LD_RD     = ctrl_q[4];
   assign SD_IRQ    = irq_r;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed-plus-random bench for sd_spi_master: bus tasks, an SPI edge monitor
// with a slave model, and expectations derived from SPI mode and FIFO rules.
module tb_sd_spi_master;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cs_drive = 1'b0, RD = 1'b1, WR = 1'b1;
   logic [1:0] ADDR = 2'd0;
   wire  [7:0] DATA;
   logic [7:0] bus_drv = 8'h00;
   logic       bus_oe = 1'b0;
   logic       CARD_DET = 1'b0;
   logic       MISO;
   logic       SCLK, MOSI, LD_GN, LD_RD, SD_IRQ;
   logic [0:0] SD_CS;
   logic [1:0] dbg_state;
   logic       loop_en = 1'b1;

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   assign DATA = bus_oe ? bus_drv : 8'hzz;

   sd_spi_master #(.DIV_W(8), .FIFO_DEPTH(DEPTH), .NUM_CS(1)) dut (
      .clk(clk), .reset(reset), .cs_drive(cs_drive), .RD(RD), .WR(WR),
      .ADDR(ADDR), .DATA(DATA), .CARD_DET(CARD_DET), .MISO(MISO),
      .SCLK(SCLK), .MOSI(MOSI), .SD_CS(SD_CS), .LD_GN(LD_GN), .LD_RD(LD_RD),
      .SD_IRQ(SD_IRQ), .dbg_state(dbg_state)
   );

   // SPI monitor and slave: edges are counted relative to ec_base per transfer.
   int         ec = 0, ec_base = 0, cyc = 0, cpha_m = 0;
   int         edge_t [16];
   logic       mon_arr [16];
   logic       sclk_prev = 1'b0;
   logic [7:0] slave_byte = 8'h3C;
   logic       slave_miso = 1'b1;

   assign MISO = loop_en ? MOSI : slave_miso;

   always @(negedge clk) begin
      int rel, idx;
      cyc++;
      rel = ec - ec_base;
      if (SCLK !== sclk_prev) begin
         if (rel >= 0 && rel < 16) begin
            edge_t[rel] = cyc;
            if ((rel % 2) == cpha_m) mon_arr[rel] = MOSI;
            else begin
               idx = (cpha_m == 0) ? (rel + 1) / 2 : rel / 2;
               if (idx < 8) slave_miso = slave_byte[7 - idx];
            end
         end
         ec++;
      end else if (rel == 0) begin
         slave_miso = (cpha_m == 0) ? slave_byte[7] : 1'b1;
      end
      sclk_prev = SCLK;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      cs_drive = 1'b1; ADDR = a; bus_drv = d; bus_oe = 1'b1; WR = 1'b0;
      repeat (2) @(negedge clk);
      WR = 1'b1;
      @(negedge clk);
      cs_drive = 1'b0; bus_oe = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      cs_drive = 1'b1; ADDR = a; RD = 1'b0;
      @(negedge clk);
      d = DATA;
      RD = 1'b1;
      @(negedge clk);
      cs_drive = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      repeat (2) @(negedge clk);
      while (dbg_state != 2'd0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_within_budget", 32'(n < budget), 32'd1);
   endtask

   // One byte in SPI mode `mode` (CPOL = mode[1], CPHA = mode[0]).
   task automatic xfer(input int mode, input int div, input logic [7:0] tx,
                       input bit loop, input bit ie);
      logic [7:0] rd, bits;
      int cpol, cpha;
      cpol = (mode >> 1) & 1;
      cpha = mode & 1;
      loop_en = loop;
      bus_write(2'd3, 8'(div));
      bus_write(2'd0, 8'(8'h04 | (cpha << 1) | cpol | (ie ? 8'h20 : 8'h00)));
      repeat (3) @(negedge clk);
      check("cs_asserted", 32'(SD_CS), 32'd0);
      check("sclk_idle", 32'(SCLK), 32'(cpol));
      cpha_m = cpha;
      ec_base = ec;
      bus_write(2'd2, tx);
      wait_idle(16 * (div + 1) + 64);
      check("sclk_edges", 32'(ec - ec_base), 32'd16);
      check("half_period", 32'(edge_t[1] - edge_t[0]), 32'(div + 1));
      for (int k = 0; k < 8; k++) bits[7 - k] = mon_arr[cpha + 2 * k];
      check("mosi_bits", 32'(bits), 32'(tx));
      check("sclk_rest", 32'(SCLK), 32'(cpol));
      check("mosi_rest", 32'(MOSI), 32'd1);
      bus_read(2'd1, rd);
      check("status_done", 32'(rd), 32'h48);
      check("irq_done", 32'(SD_IRQ), 32'(ie));
      bus_read(2'd2, rd);
      check("rx_byte", 32'(rd), 32'(loop ? tx : slave_byte));
      bus_read(2'd1, rd);
      check("status_popped", 32'(rd), 32'h58);
      bus_write(2'd1, 8'h40);
      repeat (2) @(negedge clk);
      check("irq_cleared", 32'(SD_IRQ), 32'd0);
   endtask

   initial begin
      logic [7:0] rd, b1, b2, v;
      int accepted;
      bit ovr_exp;

      // Reset state
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_sd_cs", 32'(SD_CS), 32'd1);
      check("rst_mosi", 32'(MOSI), 32'd1);
      check("rst_sclk", 32'(SCLK), 32'd0);
      check("rst_irq", 32'(SD_IRQ), 32'd0);
      bus_read(2'd1, rd); check("rst_status", 32'(rd), 32'h18);
      bus_read(2'd3, rd); check("rst_div", 32'(rd), 32'hFF);
      bus_read(2'd0, rd); check("rst_ctrl", 32'(rd), 32'h00);
      bus_read(2'd2, rd); check("rst_rx_empty_read", 32'(rd), 32'hFF);

      // LEDs and CS_SEL masking with one chip select
      bus_write(2'd0, 8'h98);
      @(negedge clk);
      check("ld_gn", 32'(LD_GN), 32'd1);
      check("ld_rd", 32'(LD_RD), 32'd1);
      check("cs_idle", 32'(SD_CS), 32'd1);
      bus_read(2'd0, rd); check("ctrl_readback", 32'(rd), 32'h18);

      // Mode 0, DIV=1, loopback 0xA5 with IE_DONE
      xfer(0, 1, 8'hA5, 1'b1, 1'b1);

      // Modes 1-3 against a slave returning 0x3C
      for (int m = 1; m < 4; m++)
         xfer(m, $urandom_range(0, 2), 8'($urandom_range(0, 255)), 1'b0, 1'b0);

      // Random loopback transfers
      for (int i = 0; i < 4; i++)
         xfer($urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom_range(0, 255)),
              1'b1, 1'($urandom_range(0, 1)));

      // FIFO fill with a slow divider: engine holds one byte, FIFO holds DEPTH
      bus_write(2'd1, 8'hE0);
      bus_write(2'd3, 8'hFF);
      bus_write(2'd0, 8'h04);
      loop_en = 1'b1;
      repeat (3) @(negedge clk);
      accepted = 0;
      ovr_exp = 1'b0;
      for (int i = 0; i < 6; i++) begin
         v = 8'($urandom_range(0, 255));
         bus_write(2'd2, v);
         repeat (2) @(negedge clk);
         if (accepted < DEPTH + 1) begin
            accepted++;
            if (exp_q.size() < DEPTH) exp_q.push_back(v);
            else ovr_exp = 1'b1;
         end
      end
      bus_read(2'd1, rd);
      check("status_tx_full", 32'(rd), 32'(8'h11 | ((accepted - 1 >= DEPTH) ? 8'h04 : 8'h00)));
      wait_idle(6 * (16 * 256 + 2) + 200);
      bus_read(2'd1, rd);
      check("status_ovr", 32'(rd), 32'(8'h48 | (ovr_exp ? 8'h20 : 8'h00)));
      while (exp_q.size() > 0) begin
         v = exp_q.pop_front();
         bus_read(2'd2, rd);
         check("rx_fifo_order", 32'(rd), 32'(v));
      end
      bus_read(2'd2, rd); check("rx_drained", 32'(rd), 32'hFF);

      // Flush during SHIFT: current byte completes, queued byte is lost
      bus_write(2'd1, 8'hE0);
      bus_write(2'd3, 8'h03);
      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      cpha_m = 0;
      ec_base = ec;
      bus_write(2'd2, b1);
      bus_write(2'd2, b2);
      repeat (4) @(negedge clk);
      bus_write(2'd1, 8'h01);
      bus_read(2'd1, rd); check("status_after_flush", 32'(rd), 32'h19);
      wait_idle(200);
      check("flush_edges", 32'(ec - ec_base), 32'd16);
      bus_read(2'd2, rd); check("flush_rx_kept", 32'(rd), 32'(b1));
      bus_read(2'd2, rd); check("flush_rx_only_one", 32'(rd), 32'hFF);

      // Card detect change with IE_CARD
      bus_write(2'd1, 8'hE0);
      bus_write(2'd0, 8'h40);
      CARD_DET = 1'b1;
      repeat (5) @(negedge clk);
      check("irq_card", 32'(SD_IRQ), 32'd1);
      bus_read(2'd1, rd); check("status_card_in", 32'(rd), 32'h9A);
      bus_write(2'd1, 8'h80);
      repeat (2) @(negedge clk);
      check("irq_card_clear", 32'(SD_IRQ), 32'd0);
      bus_read(2'd1, rd); check("status_chg_clear", 32'(rd), 32'h1A);
      CARD_DET = 1'b0;
      repeat (5) @(negedge clk);
      bus_read(2'd1, rd); check("status_card_out", 32'(rd), 32'h98);
      bus_write(2'd1, 8'h80);

      // Reset in the middle of a byte with CPOL=1
      bus_write(2'd0, 8'h05);
      bus_write(2'd3, 8'h03);
      bus_write(2'd2, 8'($urandom_range(0, 255)));
      repeat (20) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_sclk", 32'(SCLK), 32'd0);
      check("midrst_mosi", 32'(MOSI), 32'd1);
      check("midrst_cs", 32'(SD_CS), 32'd1);
      check("midrst_irq", 32'(SD_IRQ), 32'd0);
      bus_read(2'd1, rd); check("midrst_status", 32'(rd), 32'h18);
      bus_read(2'd3, rd); check("midrst_div", 32'(rd), 32'hFF);
      bus_read(2'd2, rd); check("midrst_rx_empty", 32'(rd), 32'hFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sd_spi_master.md
# sd_spi_master

Parametrised SPI master for the Mini8086 I/O space, successor to the single-byte SD card controller. It adds TX/RX byte FIFOs, a register-programmable clock divider, all four SPI modes (CPOL/CPHA), up to two chip selects, overrun detection, and maskable interrupts on transfer-done and card-detect change. It sits behind the I/O address decoder on the 8-bit CPU data bus and drives the SD card socket directly.

## Interface
- DIV_W, 8: divider register width (1..8); half-period = DIV+1 clk cycles
- FIFO_DEPTH, 4: TX and RX FIFO depth, power of two, 2..16
- NUM_CS, 1: number of chip-select outputs (1 or 2)
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- cs_drive  in  1  block select from the I/O decoder, active high
- RD  in  1  bus read strobe, active low
- WR  in  1  bus write strobe, active low
- ADDR  in  2  register select: 0 control, 1 status, 2 data, 3 divider
- DATA  inout  8  CPU data bus; driven only while cs_drive & ~RD, else Z
- CARD_DET  in  1  card present, high = inserted (asynchronous)
- MISO  in  1  SPI serial in
- SCLK  out  1  SPI clock
- MOSI  out  1  SPI serial out
- SD_CS  out  NUM_CS  chip selects, active low
- LD_GN, LD_RD  out  1 each  LED drives
- SD_IRQ  out  1  interrupt request, active-high level

## Operation
- Control (addr 0, R/W): [0] CPOL, [1] CPHA, [2] CS_ASSERT, [3] LD_GN, [4] LD_RD, [5] IE_DONE, [6] IE_CARD, [7] CS_SEL (ignored, reads 0 when NUM_CS=1). SD_CS[i] = ~(CS_ASSERT & CS_SEL==i).
- Status (addr 1): read [0] BUSY (engine active or TX not empty), [1] CARD (synchronised), [2] TX_FULL, [3] TX_EMPTY, [4] RX_EMPTY, [5] OVR, [6] DONE, [7] CARD_CHG. Write: bit0=1 flushes both FIFOs; bits 5/6/7 write-1-to-clear.
- Data (addr 2): write pushes TX FIFO; dropped silently if full. Read returns RX head (0xFF when empty); pop occurs on RD rising edge while selected.
- Divider (addr 3): DIV_W bits, upper bits read 0.
- Bus writes commit once, on the first clk where cs_drive & ~WR is seen after WR was high (falling-edge detect on a registered WR).
- Engine FSM: IDLE -> LOAD (TX not empty: pop byte, latch CPOL/CPHA/DIV) -> SHIFT (16 half-bit ticks) -> DONE (push RX) -> LOAD or IDLE.
- CPHA=0: MOSI valid in LOAD, sample MISO on leading edge, shift on trailing. CPHA=1: shift on leading, sample on trailing. MSB first. SCLK rests at CPOL; MOSI rests high.
- DONE: RX full -> byte discarded, OVR set. DONE flag set when DONE state leaves with TX empty.
- CARD_DET: 2-FF synchroniser; any change of synchronised value sets CARD_CHG.
- SD_IRQ = (IE_DONE & DONE) | (IE_CARD & CARD_CHG), registered.

## Timing
- Reset values: control 0x00 (SD_CS all 1, LEDs 0, IRQs off), divider all ones, FIFOs empty, flags 0, SCLK 0, MOSI 1, SD_IRQ 0, FSM IDLE.
- Data write -> first SCLK edge: 3 clk (push, LOAD, first SHIFT tick at DIV+1 later). Byte time = 16*(DIV+1) + 2 clk; back-to-back bytes without idle gap.
- RX byte readable 1 clk after DONE; status bits reflect it same cycle.
- Push and pop in the same cycle on a full TX FIFO: push accepted.
- Config/divider writes during SHIFT affect the next LOAD only.
- Flush during SHIFT: current byte completes and is pushed into the emptied RX FIFO.
- W1C and hardware set in same cycle: set wins.
- reset mid-transfer: all state to reset values next clk, no partial RX push.

## Test plan
- Reset -> SD_CS=all 1, MOSI=1, SCLK=0, status=0x18 (CARD=0), divider reads 0xFF.
- DIV=1, mode 0, write 0xA5 with MISO looped to MOSI -> 8 SCLK pulses of 4 clk period, MOSI 1,0,1,0,0,1,0,1, RX read 0xA5, DONE set, SD_IRQ when IE_DONE=1.
- Modes 1-3 with slave model returning 0x3C -> correct SCLK idle level, RX 0x3C each mode.
- Write 6 bytes with FIFO_DEPTH=4 while engine idle-blocked by divider 0xFF -> bytes 6+ dropped only when full; RX never read -> 5th completion sets OVR.
- Toggle CARD_DET with IE_CARD=1 -> CARD_CHG and SD_IRQ after 3 clk; write 0x80 to status -> both clear.
- Assert reset mid-byte -> next clk IDLE, SCLK=CPOL reset 0, RX_EMPTY=1.
